// File: rtl/seq_subtractor_16bit.sv
// seq_subtractor_16bit: multi-cycle two's-complement A - B, CHUNK bits per clock
// with the inter-chunk carry held in a register so the adder cell stays CHUNK bits wide.
module seq_subtractor_16bit #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);
  localparam int NCH = (CHUNK > 0) ? WIDTH / CHUNK : 1;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  if (CHUNK == 0) begin : g_bad_chunk
    $fatal(1, "seq_subtractor_16bit: CHUNK must be nonzero");
  end else if ((WIDTH % CHUNK) != 0) begin : g_bad_width
    $fatal(1, "seq_subtractor_16bit: WIDTH must be a multiple of CHUNK");
  end
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, d_q, d_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d, bout_q, bout_d, ovf_q, ovf_d, zero_q, zero_d;
  logic [CHUNK-1:0] sum_s;
  logic             sum_c, accept, last;
  assign accept = start && (state_q != RUN);
  assign last   = (idx_q == IW'(NCH - 1));
  // One chunk of A + ~B + carry; the initial carry of 1 supplies the +1 of the negation.
  always_comb begin
    {sum_c, sum_s} = {1'b0, a_q[idx_q*CHUNK +: CHUNK]} + {1'b0, ~b_q[idx_q*CHUNK +: CHUNK]}
                   + (CHUNK+1)'(carry_q);
  end
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    d_d     = d_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    if (state_q == RUN) begin
      acc_d[idx_q*CHUNK +: CHUNK] = sum_s;
      carry_d = sum_c;
      idx_d   = idx_q + IW'(1);
      if (last) begin
        state_d = DONE;
        d_d     = acc_d;
        bout_d  = ~sum_c;
        ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (acc_d[WIDTH-1] != a_q[WIDTH-1]);
        zero_d  = ~|acc_d;
      end
    end else if (accept) begin
      state_d = RUN;
      a_d     = A;
      b_d     = B;
      idx_d   = '0;
      carry_d = 1'b1;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      d_q     <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign D    = d_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;
endmodule
